shared_pipe_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-latency pipelined arithmetic unit (adder/multiplier class, no internal stall) among NUM_REQ requesters. It grants at most one operand pair per cycle into the pipe and tracks each in-flight operation's requester ID in a tag shift register. It routes each result back to the requester that issued it, and supports flush with drain. It also checks that the pipe's output valid matches the tracked tags.

---
 rtl/shared_pipe_if.sv | 31 +++
 rtl/shared_pipe_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_shared_pipe_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/shared_pipe_if.sv
// Requester, shared-pipe and response signals of the shared pipe scheduler.
// slave is the scheduler side; master is the requester/pipe side.
interface shared_pipe_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          flush;
   logic                          pipe_in_valid;
   logic [DATA_WIDTH-1:0]         pipe_a;
   logic [DATA_WIDTH-1:0]         pipe_b;
   logic                          pipe_out_valid;
   logic [DATA_WIDTH-1:0]         pipe_result;
   logic [NUM_REQ-1:0]            resp_valid;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic                          busy;
   logic                          tag_error;

   modport slave (
      input  req_valid, req_a, req_b, flush, pipe_out_valid, pipe_result,
      output req_ready, pipe_in_valid, pipe_a, pipe_b, resp_valid, resp_data, busy, tag_error
   );

   modport master (
      output req_valid, req_a, req_b, flush, pipe_out_valid, pipe_result,
      input  req_ready, pipe_in_valid, pipe_a, pipe_b, resp_valid, resp_data, busy, tag_error
   );
endinterface

// File: rtl/shared_pipe_scheduler.sv
// Round-robin sharing of one fixed-latency pipe among NUM_REQ requesters with tag tracking.
// Optional SHARED_PIPE_STATS_EN adds per-requester saturating grant counters (grant_count).
module shared_pipe_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 3
) (
   input  logic              clk,
   input  logic              rst,
   shared_pipe_if.slave      bus
`ifdef SHARED_PIPE_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] grant_count
`endif
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   drain_q, drain_d;
   logic [LATENCY-1:0] tag_v_q, tag_v_d;
   logic [IDX_W-1:0]   tag_id_q [LATENCY];
   logic [IDX_W-1:0]   tag_id_d [LATENCY];
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic               tag_error_q, tag_error_d;

   logic               grant_found;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   cand;
   logic               tail_v;
   logic [IDX_W-1:0]   tail_id;
   logic               deliver;

   // Search upward from rr_ptr; flush and FLUSH state suppress all grants.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (state_q != ST_FLUSH && !bus.flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
               grant_found = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      bus.req_ready     = '0;
      bus.pipe_in_valid = grant_found;
      bus.pipe_a        = '0;
      bus.pipe_b        = '0;
      if (grant_found) begin
         bus.req_ready[grant_idx] = 1'b1;
         bus.pipe_a = bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         bus.pipe_b = bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_found) begin
         rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign tail_v  = tag_v_q[LATENCY-1];
   assign tail_id = tag_id_q[LATENCY-1];

   always_comb begin
      tag_v_d     = '0;
      tag_v_d[0]  = grant_found;
      tag_id_d[0] = grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
      if (bus.flush) begin
         tag_v_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               state_d = ST_FLUSH;
               drain_d = CNT_W'(LATENCY);
            end else if (grant_found) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               state_d = ST_FLUSH;
               drain_d = CNT_W'(LATENCY);
            end else if (tag_v_d == '0) begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (bus.flush) begin
               drain_d = CNT_W'(LATENCY);
            end else if (drain_q <= CNT_W'(1)) begin
               drain_d = '0;
               state_d = ST_IDLE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            drain_d = '0;
         end
      endcase
   end

   // Results are dropped while draining and in the cycle flush is asserted.
   assign deliver = bus.pipe_out_valid && tail_v && (state_q != ST_FLUSH) && !bus.flush;

   always_comb begin
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      if (deliver) begin
         resp_valid_d[tail_id] = 1'b1;
         resp_data_d           = bus.pipe_result;
      end
      tag_error_d = tag_error_q |
                    ((state_q != ST_FLUSH) && (bus.pipe_out_valid != tail_v));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         drain_q      <= '0;
         tag_v_q      <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         tag_error_q  <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         drain_q      <= drain_d;
         tag_v_q      <= tag_v_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         tag_error_q  <= tag_error_d;
         for (int i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= tag_id_d[i];
         end
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.tag_error  = tag_error_q;
   assign bus.busy       = (tag_v_q != '0) || (state_q != ST_IDLE);

`ifdef SHARED_PIPE_STATS_EN
   logic [15:0] gcnt_q [NUM_REQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_q[i] <= '0;
         end
      end else if (grant_found && gcnt_q[grant_idx] != 16'hFFFF) begin
         gcnt_q[grant_idx] <= gcnt_q[grant_idx] + 16'd1;
      end
   end

   always_comb begin
      grant_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_count[i*16 +: 16] = gcnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_shared_pipe_scheduler.sv
// Directed bench for shared_pipe_scheduler with a LATENCY-stage a+b pipe model.
module tb_shared_pipe_scheduler;
   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 3;

   logic clk;
   logic rst;
   logic inject;
   int   compared;
   int   mismatched;

   shared_pipe_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef SHARED_PIPE_STATS_EN
   logic [NR*16-1:0] grant_count;
`endif

   shared_pipe_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave)
`ifdef SHARED_PIPE_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   always #5 clk = ~clk;

   // Pipe model: result = a + b, LAT cycles after issue; inject forces a spurious strobe.
   logic [LAT-1:0] stg_v;
   logic [DW-1:0]  stg_d [LAT];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_v <= '0;
      end else begin
         stg_v[0] <= bus.pipe_in_valid;
         stg_d[0] <= bus.pipe_a + bus.pipe_b;
         for (int i = 1; i < LAT; i++) begin
            stg_v[i] <= stg_v[i-1];
            stg_d[i] <= stg_d[i-1];
         end
      end
   end

   assign bus.pipe_out_valid = stg_v[LAT-1] | inject;
   assign bus.pipe_result    = stg_d[LAT-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] exp_sum [NR];

   initial begin
      compared      = 0;
      mismatched    = 0;
      clk           = 1'b0;
      rst           = 1'b1;
      inject        = 1'b0;
      bus.req_valid = '0;
      bus.flush     = 1'b0;
      for (int i = 0; i < NR; i++) begin
         bus.req_a[i*DW +: DW] = 32'(i * 16 + 1);
         bus.req_b[i*DW +: DW] = 32'h100;
      end
      exp_sum = '{32'h101, 32'h111, 32'h121, 32'h131};

      #2;
      check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("rst_resp_data", 64'(bus.resp_data), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_tag_error", 64'(bus.tag_error), 64'h0);
      check("rst_req_ready", 64'(bus.req_ready), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // All requesters active for 8 cycles: grants rotate 0..3 twice.
      for (int n = 0; n < 12; n++) begin
         step();
         bus.req_valid = (n < 8) ? 4'hF : 4'h0;
         #1;
         check("rr_ready", 64'(bus.req_ready), (n < 8) ? (64'h1 << (n % 4)) : 64'h0);
         if (n >= 4) begin
            check("rr_resp_valid", 64'(bus.resp_valid), 64'h1 << ((n - 4) % 4));
            check("rr_resp_data", 64'(bus.resp_data), 64'(exp_sum[(n - 4) % 4]));
         end else begin
            check("rr_resp_idle", 64'(bus.resp_valid), 64'h0);
         end
      end

      // Single request from requester 2: 5 + 7.
      step();
      bus.req_a[2*DW +: DW] = 32'd5;
      bus.req_b[2*DW +: DW] = 32'd7;
      bus.req_valid = 4'b0100;
      #1;
      check("single_ready", 64'(bus.req_ready), 64'h4);
      check("single_pipe_in_valid", 64'(bus.pipe_in_valid), 64'h1);
      check("single_pipe_a", 64'(bus.pipe_a), 64'd5);
      check("single_pipe_b", 64'(bus.pipe_b), 64'd7);
      step();
      bus.req_valid = 4'b0000;
      #1;
      check("single_pipe_idle", 64'(bus.pipe_in_valid), 64'h0);
      check("single_pipe_a_zero", 64'(bus.pipe_a), 64'h0);
      check("single_busy", 64'(bus.busy), 64'h1);
      step();
      step();
      check("single_resp_early", 64'(bus.resp_valid), 64'h0);
      check("single_busy_tail", 64'(bus.busy), 64'h1);
      step();
      check("single_resp_valid", 64'(bus.resp_valid), 64'h4);
      check("single_resp_data", 64'(bus.resp_data), 64'd12);
      step();
      check("single_resp_drop", 64'(bus.resp_valid), 64'h0);
      check("single_resp_hold", 64'(bus.resp_data), 64'd12);
      check("single_busy_low", 64'(bus.busy), 64'h0);

      // Three grants (rr_ptr=3 -> 3,0,1), then flush with requests still pending.
      for (int n = 0; n < 3; n++) begin
         step();
         bus.req_valid = 4'hF;
         #1;
         check("fl_grant", 64'(bus.req_ready), 64'h1 << ((n + 3) % 4));
      end
      step();
      bus.flush = 1'b1;
      #1;
      check("fl_ready_flush", 64'(bus.req_ready), 64'h0);
      check("fl_pipe_in_flush", 64'(bus.pipe_in_valid), 64'h0);
      check("fl_resp_flush", 64'(bus.resp_valid), 64'h0);
      for (int n = 0; n < 3; n++) begin
         step();
         bus.flush = 1'b0;
         #1;
         check("fl_ready_drain", 64'(bus.req_ready), 64'h0);
         check("fl_resp_drain", 64'(bus.resp_valid), 64'h0);
         check("fl_busy_drain", 64'(bus.busy), 64'h1);
      end
      step();
      bus.req_valid = 4'h0;
      #1;
      check("fl_busy_done", 64'(bus.busy), 64'h0);
      check("fl_resp_done", 64'(bus.resp_valid), 64'h0);
      check("fl_tag_error", 64'(bus.tag_error), 64'h0);

      // Two ops in flight (rr_ptr=2 -> 2,3), then asynchronous reset.
      step();
      bus.req_valid = 4'hF;
      #1;
      check("rs_grant0", 64'(bus.req_ready), 64'h4);
      step();
      #1;
      check("rs_grant1", 64'(bus.req_ready), 64'h8);
      step();
      bus.req_valid = 4'h0;
      #1;
      rst = 1'b1;
      #1;
      check("rs_resp_now", 64'(bus.resp_valid), 64'h0);
      check("rs_busy_now", 64'(bus.busy), 64'h0);
      step();
      check("rs_resp_hold", 64'(bus.resp_valid), 64'h0);
      step();
      rst = 1'b0;
      #1;
      check("rs_resp_after", 64'(bus.resp_valid), 64'h0);
      step();
      bus.req_valid = 4'hF;
      #1;
      check("rs_first_grant", 64'(bus.req_ready), 64'h1);
      check("rs_resp_none", 64'(bus.resp_valid), 64'h0);
      step();
      #1;
      check("rs_second_grant", 64'(bus.req_ready), 64'h2);
      step();
      bus.req_valid = 4'h0;
      repeat (6) step();
      check("rs_drained", 64'(bus.busy), 64'h0);
      check("rs_no_error", 64'(bus.tag_error), 64'h0);

      // Spurious pipe strobe with nothing in flight.
      step();
      inject = 1'b1;
      #1;
      check("te_before", 64'(bus.tag_error), 64'h0);
      step();
      inject = 1'b0;
      #1;
      check("te_set", 64'(bus.tag_error), 64'h1);
      repeat (3) step();
      check("te_sticky", 64'(bus.tag_error), 64'h1);
      rst = 1'b1;
      #1;
      check("te_cleared", 64'(bus.tag_error), 64'h0);
      step();
      rst = 1'b0;

`ifdef SHARED_PIPE_STATS_EN
      step();
      bus.req_valid = 4'b0001;
      for (int n = 0; n < 70000; n++) begin
         step();
      end
      bus.req_valid = 4'b0000;
      #1;
      check("stats_saturated", 64'(grant_count[15:0]), 64'hFFFF);
      check("stats_other", 64'(grant_count[31:16]), 64'h0);
      repeat (6) step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
